// File: rtl/freelist_pkg.sv
// Shared types and sizes for the physical-register free list.
package freelist_pkg;

   localparam int unsigned PREG_NUM     = 64;
   localparam int unsigned ARCH_REG_NUM = 32;
   localparam int unsigned DEPTH        = PREG_NUM - ARCH_REG_NUM;
   localparam int unsigned PREG_W       = $clog2(PREG_NUM);
   localparam int unsigned IDX_W        = $clog2(DEPTH);
   localparam int unsigned PTR_W        = IDX_W + 1;

   typedef logic [PREG_W-1:0] preg_t;

   // Wrap bit distinguishes full from empty when indices match.
   typedef struct packed {
      logic             wrap;
      logic [IDX_W-1:0] idx;
   } fl_ptr_t;

endpackage

// File: rtl/freelist_ptr_add.sv
// Free-list pointer advance by 0, 1 or 2 entries; the wrap bit toggles on index overflow.
module freelist_ptr_add
   import freelist_pkg::*;
(
   input  fl_ptr_t    ptr_i,
   input  logic [1:0] inc_i,
   output fl_ptr_t    sum_o
);

   always_comb begin
      sum_o = fl_ptr_t'(PTR_W'(ptr_i) + PTR_W'(inc_i));
   end

endmodule

// File: rtl/freelist.sv
// Circular free list of physical register IDs with speculative and architectural heads.
// Optional duplicate-release detection is enabled with FREELIST_DUP_CHECK_EN.
module freelist
   import freelist_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             instr0_freelist_req,
   output preg_t            instr0_freelist_resp,
   input  logic             instr1_freelist_req,
   output preg_t            instr1_freelist_resp,
   output logic [PTR_W-1:0] freelist_avail_cnt,
   output logic             freelist_can_alloc2,
   input  logic             commit0_valid,
   input  logic             commit0_need_to_wb,
   input  preg_t            commit0_old_prd,
   input  logic             commit1_valid,
   input  logic             commit1_need_to_wb,
   input  preg_t            commit1_old_prd,
   input  logic             flush_valid
`ifdef FREELIST_DUP_CHECK_EN
   ,
   output logic             freelist_dup_err
`endif
);

   preg_t            list_q [DEPTH];
   preg_t            list_d [DEPTH];
   fl_ptr_t          spec_head_q, spec_head_d;
   fl_ptr_t          arch_head_q, arch_head_d;
   fl_ptr_t          tail_q, tail_d;
   fl_ptr_t          spec_adv, tail_adv, arch_adv;
   logic             rel0, rel1, alloc_ok;
   logic [1:0]       n_alloc, n_rel, alloc_inc;
   logic [PTR_W-1:0] avail;
   logic [IDX_W-1:0] spec_idx1, tail_idx1;

   always_comb begin
      rel0      = commit0_valid & commit0_need_to_wb;
      rel1      = commit1_valid & commit1_need_to_wb;
      n_alloc   = 2'(instr0_freelist_req) + 2'(instr1_freelist_req);
      n_rel     = 2'(rel0) + 2'(rel1);
      avail     = tail_q - spec_head_q;
      // Oversized requests are dropped whole; flush suppresses allocation.
      alloc_ok  = !flush_valid && (PTR_W'(n_alloc) <= avail);
      alloc_inc = alloc_ok ? n_alloc : 2'd0;
      spec_idx1 = spec_head_q.idx + IDX_W'(1);
      tail_idx1 = tail_q.idx + IDX_W'(rel0);
   end

   freelist_ptr_add u_spec_add (.ptr_i(spec_head_q), .inc_i(alloc_inc), .sum_o(spec_adv));
   freelist_ptr_add u_tail_add (.ptr_i(tail_q),      .inc_i(n_rel),     .sum_o(tail_adv));
   freelist_ptr_add u_arch_add (.ptr_i(arch_head_q), .inc_i(n_rel),     .sum_o(arch_adv));

   always_comb begin
      instr0_freelist_resp = list_q[spec_head_q.idx];
      instr1_freelist_resp = instr0_freelist_req ? list_q[spec_idx1] : list_q[spec_head_q.idx];
      freelist_avail_cnt   = avail;
      freelist_can_alloc2  = (avail >= PTR_W'(2));
   end

   always_comb begin
      list_d = list_q;
      if (rel0) list_d[tail_q.idx] = commit0_old_prd;
      if (rel1) list_d[tail_idx1]  = commit1_old_prd;
      tail_d      = tail_adv;
      arch_head_d = arch_adv;
      spec_head_d = flush_valid ? arch_adv : spec_adv;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            list_q[i] <= PREG_W'(ARCH_REG_NUM + i);
         end
         spec_head_q <= '0;
         arch_head_q <= '0;
         tail_q      <= '{wrap: 1'b1, idx: '0};
      end else begin
         list_q      <= list_d;
         spec_head_q <= spec_head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
      end
   end

`ifdef FREELIST_DUP_CHECK_EN
   logic [PREG_NUM-1:0] in_list_q, in_list_d;
   logic                dup_err_q, dup_err_d;
   logic [PTR_W-1:0]    restore_cnt;
   logic [IDX_W-1:0]    off;

   // Bitmap tracks which IDs currently sit in the list; a second release of one is an error.
   always_comb begin
      in_list_d   = in_list_q;
      dup_err_d   = dup_err_q;
      restore_cnt = spec_head_q - arch_adv;
      off         = '0;
      if (alloc_ok && instr0_freelist_req) in_list_d[instr0_freelist_resp] = 1'b0;
      if (alloc_ok && instr1_freelist_req) in_list_d[instr1_freelist_resp] = 1'b0;
      if (rel0) begin
         if (in_list_q[commit0_old_prd]) dup_err_d = 1'b1;
         in_list_d[commit0_old_prd] = 1'b1;
      end
      if (rel1) begin
         if (in_list_q[commit1_old_prd] || (rel0 && commit0_old_prd == commit1_old_prd)) begin
            dup_err_d = 1'b1;
         end
         in_list_d[commit1_old_prd] = 1'b1;
      end
      if (flush_valid) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            off = IDX_W'(i) - arch_adv.idx;
            if (PTR_W'(off) < restore_cnt) in_list_d[list_q[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_list_q <= {{DEPTH{1'b1}}, {ARCH_REG_NUM{1'b0}}};
         dup_err_q <= 1'b0;
      end else begin
         in_list_q <= in_list_d;
         dup_err_q <= dup_err_d;
      end
   end

   assign freelist_dup_err = dup_err_q;
`endif

endmodule
